// File: rtl/mux_stream_rr_pkg.sv
// Shared mode encodings and select-width helper for the stream multiplexer family.
package mux_stream_rr_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Returns at least 1 so that two-input (and degenerate) muxes still get a usable index field.
    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_stream_rr_rr_arbiter.sv
// Round-robin arbiter: scans from ptr upward, wrapping at NUM_IN; one-hot grant plus index.
// Latency: combinational. Backpressure: none, the caller qualifies the grant with its own ready.
module rr_arbiter
    import mux_stream_rr_pkg::*;
#(
    parameter int NUM_IN = 4,
    parameter int SEL_W  = sel_width(NUM_IN)
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic [NUM_IN-1:0] grant,
    output logic [SEL_W-1:0]  idx
);

    localparam int CW = SEL_W + 1;

    logic [CW-1:0] pos;
    logic          found;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            // ptr is always < NUM_IN, so one subtraction is enough to wrap.
            pos = {1'b0, ptr} + CW'(k);
            if (pos >= CW'(NUM_IN)) begin
                pos = pos - CW'(NUM_IN);
            end
            if (!found && req[pos[SEL_W-1:0]]) begin
                found                   = 1'b1;
                grant[pos[SEL_W-1:0]]   = 1'b1;
                idx                     = pos[SEL_W-1:0];
            end
        end
    end

endmodule

// File: rtl/mux_stream_rr.sv
// N:1 valid/ready stream mux with fixed-select or round-robin arbitration.
// Latency: 1 cycle to a registered output. Backpressure: a stalled output beat drops every in_ready.
module mux_stream_rr
    import mux_stream_rr_pkg::*;
#(
    parameter int WIDTH  = 3,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = sel_width(NUM_IN)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_IN*WIDTH-1:0]  in_data,
    input  logic [NUM_IN-1:0]        in_valid,
    output logic [NUM_IN-1:0]        in_ready,
    input  logic                     mode,
    input  logic [SEL_W-1:0]         sel,
    output logic [WIDTH-1:0]         out_data,
    output logic [SEL_W-1:0]         out_src,
    output logic                     out_valid,
    input  logic                     out_ready
);

    logic [SEL_W-1:0]  ptr;
    logic [NUM_IN-1:0] arb_grant;
    logic [SEL_W-1:0]  arb_idx;
    logic [NUM_IN-1:0] sel_oh;
    logic [NUM_IN-1:0] cand_oh;
    logic [WIDTH-1:0]  cand_dat;
    logic [SEL_W-1:0]  cand_src;
    logic              pipe_ready;
    logic              xfer;

    rr_arbiter #(
        .NUM_IN (NUM_IN),
        .SEL_W  (SEL_W)
    ) u_arb (
        .req   (in_valid),
        .ptr   (ptr),
        .grant (arb_grant),
        .idx   (arb_idx)
    );

    assign pipe_ready = !out_valid || out_ready;

    // Out-of-range sel decodes to no channel at all, so no in_ready and no transfer.
    always_comb begin
        sel_oh = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            sel_oh[i] = (sel == SEL_W'(i));
        end
    end

    always_comb begin
        cand_oh  = (mode == MODE_RR) ? arb_grant : sel_oh;
        cand_src = (mode == MODE_RR) ? arb_idx : sel;
        cand_dat = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (cand_oh[i]) begin
                cand_dat = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign in_ready = (reset || !pipe_ready) ? '0 : cand_oh;
    assign xfer     = |(in_valid & in_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            ptr       <= '0;
        end else begin
            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= cand_dat;
                out_src   <= cand_src;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (xfer && (mode == MODE_RR)) begin
                ptr <= (arb_idx == SEL_W'(NUM_IN - 1)) ? '0 : arb_idx + SEL_W'(1);
            end
        end
    end

endmodule
